bcd_calendar_counter: RTL and testbench

BCD_CALENDAR_COUNTER -- requirements
Module: bcd_calendar_counter

---
 rtl/calendar_pkg.sv | 65 ++++++
 rtl/bcd_calendar_counter_if.sv | 26 ++
 rtl/bcd_leap_detect.sv | 16 +
 rtl/bcd_calendar_counter.sv | 144 ++++++++++++++
 tb/tb_bcd_calendar_counter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calendar_pkg.sv
// Shared calendar definitions: BCD month codes, leap-mode encodings and
// the BCD helpers used by the counter and its leap detector.
package calendar_pkg;

    typedef enum int unsigned {
        LEAP_MOD4      = 0,
        LEAP_GREGORIAN = 1
    } leap_mode_e;

    localparam logic [7:0] MON_JAN = 8'h01;
    localparam logic [7:0] MON_FEB = 8'h02;
    localparam logic [7:0] MON_MAR = 8'h03;
    localparam logic [7:0] MON_APR = 8'h04;
    localparam logic [7:0] MON_MAY = 8'h05;
    localparam logic [7:0] MON_JUN = 8'h06;
    localparam logic [7:0] MON_JUL = 8'h07;
    localparam logic [7:0] MON_AUG = 8'h08;
    localparam logic [7:0] MON_SEP = 8'h09;
    localparam logic [7:0] MON_OCT = 8'h10;
    localparam logic [7:0] MON_NOV = 8'h11;
    localparam logic [7:0] MON_DEC = 8'h12;

    localparam logic [7:0] DAY_FIRST = 8'h01;

    function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic leap);
        logic [7:0] dim;
        case (month)
            MON_JAN, MON_MAR, MON_MAY, MON_JUL,
            MON_AUG, MON_OCT, MON_DEC: dim = 8'h31;
            MON_APR, MON_JUN, MON_SEP, MON_NOV: dim = 8'h30;
            MON_FEB: dim = leap ? 8'h29 : 8'h28;
            default: dim = 8'h00;
        endcase
        return dim;
    endfunction

    function automatic logic bcd_digit_ok(input logic [3:0] nib);
        return nib <= 4'h9;
    endfunction

    // Two-digit BCD increment; callers never present 99.
    function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'h9) r = {v[7:4] + 4'h1, 4'h0};
        else                r = {v[7:4], v[3:0] + 4'h1};
        return r;
    endfunction

    // A two-digit BCD value is divisible by 4 exactly when these digit rules hold.
    function automatic logic leap_pair(input logic [3:0] tens, input logic [3:0] ones);
        logic even_ok;
        logic odd_ok;
        even_ok = !tens[0] && (ones == 4'h0 || ones == 4'h4 || ones == 4'h8);
        odd_ok  =  tens[0] && (ones == 4'h2 || ones == 4'h6);
        return even_ok || odd_ok;
    endfunction

    function automatic logic leap_bcd(input logic [15:0] year, input logic gregorian);
        logic r;
        if (gregorian && year[7:0] == 8'h00) r = leap_pair(year[15:12], year[11:8]);
        else                                 r = leap_pair(year[7:4], year[3:0]);
        return r;
    endfunction

endpackage

// File: rtl/bcd_calendar_counter_if.sv
// Command/status bundle of the BCD calendar counter.
interface bcd_calendar_counter_if #(
    parameter int unsigned YEAR_DIGITS = 4
);
    logic                       day_tick;
    logic                       load;
    logic [7:0]                 load_day;
    logic [7:0]                 load_month;
    logic [4*YEAR_DIGITS-1:0]   load_year;
    logic [7:0]                 day;
    logic [7:0]                 month;
    logic [4*YEAR_DIGITS-1:0]   year;
    logic                       leap;
    logic                       year_wrap;
    logic                       load_err;

    modport master (
        output day_tick, load, load_day, load_month, load_year,
        input  day, month, year, leap, year_wrap, load_err
    );

    modport slave (
        input  day_tick, load, load_day, load_month, load_year,
        output day, month, year, leap, year_wrap, load_err
    );
endinterface

// File: rtl/bcd_leap_detect.sv
// Combinational leap-year flag for a BCD year of YEAR_DIGITS digits.
module bcd_leap_detect
    import calendar_pkg::*;
#(
    parameter int unsigned YEAR_DIGITS = 4,
    parameter int unsigned LEAP_MODE   = 1
) (
    input  logic [4*YEAR_DIGITS-1:0] year,
    output logic                     leap
);
    localparam logic GREGORIAN = (LEAP_MODE == int'(LEAP_GREGORIAN)) && (YEAR_DIGITS == 4);

    always_comb begin
        leap = leap_bcd(16'(year), GREGORIAN);
    end
endmodule

// File: rtl/bcd_calendar_counter.sv
// BCD day/month/year counter with validated loads, day ticks and a
// registered leap flag that tracks the year it describes.
module bcd_calendar_counter
    import calendar_pkg::*;
#(
    parameter int unsigned YEAR_DIGITS = 4,
    parameter int unsigned LEAP_MODE   = 1,
    parameter logic [15:0] RESET_YEAR  = 16'h2000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bcd_calendar_counter_if.slave  cal
);
    localparam int unsigned     YW        = 4 * YEAR_DIGITS;
    localparam logic            GREGORIAN = (LEAP_MODE == int'(LEAP_GREGORIAN)) && (YEAR_DIGITS == 4);
    localparam logic [YW-1:0]   RST_YEAR  = RESET_YEAR[YW-1:0];
    localparam logic            RST_LEAP  = leap_bcd(16'(RST_YEAR), GREGORIAN);

    if (YEAR_DIGITS != 2 && YEAR_DIGITS != 4) begin : g_bad_digits
        $fatal(1, "bcd_calendar_counter: YEAR_DIGITS must be 2 or 4");
    end
    if (LEAP_MODE > 1) begin : g_bad_mode
        $fatal(1, "bcd_calendar_counter: LEAP_MODE must be 0 or 1");
    end
    if (LEAP_MODE == 1 && YEAR_DIGITS != 4) begin : g_bad_combo
        $fatal(1, "bcd_calendar_counter: LEAP_MODE 1 requires YEAR_DIGITS 4");
    end

    logic [7:0]    day_q, day_d;
    logic [7:0]    month_q, month_d;
    logic [YW-1:0] year_q, year_d;
    logic          leap_q, leap_d;
    logic          year_wrap_q, year_wrap_d;
    logic          load_err_q, load_err_d;

    logic [YW-1:0] year_next;
    logic          year_carry;
    logic          next_leap;
    logic          load_leap;
    logic          load_digits_ok;
    logic          load_ok;

    // Ripple BCD increment; a carry out of the top digit means all 9s wrapped.
    always_comb begin
        year_next  = year_q;
        year_carry = 1'b1;
        for (int unsigned i = 0; i < YEAR_DIGITS; i++) begin
            if (year_carry) begin
                if (year_q[4*i +: 4] == 4'h9) begin
                    year_next[4*i +: 4] = 4'h0;
                end else begin
                    year_next[4*i +: 4] = year_q[4*i +: 4] + 4'h1;
                    year_carry          = 1'b0;
                end
            end
        end
    end

    bcd_leap_detect #(
        .YEAR_DIGITS (YEAR_DIGITS),
        .LEAP_MODE   (LEAP_MODE)
    ) u_leap_next (
        .year (year_next),
        .leap (next_leap)
    );

    bcd_leap_detect #(
        .YEAR_DIGITS (YEAR_DIGITS),
        .LEAP_MODE   (LEAP_MODE)
    ) u_leap_load (
        .year (cal.load_year),
        .leap (load_leap)
    );

    always_comb begin
        load_digits_ok = bcd_digit_ok(cal.load_day[7:4])   && bcd_digit_ok(cal.load_day[3:0]) &&
                         bcd_digit_ok(cal.load_month[7:4]) && bcd_digit_ok(cal.load_month[3:0]);
        for (int unsigned i = 0; i < YEAR_DIGITS; i++) begin
            load_digits_ok = load_digits_ok && bcd_digit_ok(cal.load_year[4*i +: 4]);
        end
        load_ok = load_digits_ok &&
                  (cal.load_month >= MON_JAN) && (cal.load_month <= MON_DEC) &&
                  (cal.load_day >= DAY_FIRST) &&
                  (cal.load_day <= days_in_month(cal.load_month, load_leap));
    end

    always_comb begin
        day_d       = day_q;
        month_d     = month_q;
        year_d      = year_q;
        leap_d      = leap_q;
        year_wrap_d = 1'b0;
        load_err_d  = 1'b0;
        if (cal.load) begin
            if (load_ok) begin
                day_d   = cal.load_day;
                month_d = cal.load_month;
                year_d  = cal.load_year;
                leap_d  = load_leap;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (cal.day_tick) begin
            if (day_q < days_in_month(month_q, leap_q)) begin
                day_d = bcd_inc2(day_q);
            end else begin
                day_d = DAY_FIRST;
                if (month_q != MON_DEC) begin
                    month_d = bcd_inc2(month_q);
                end else begin
                    month_d     = MON_JAN;
                    year_d      = year_next;
                    leap_d      = next_leap;
                    year_wrap_d = year_carry;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_q       <= DAY_FIRST;
            month_q     <= MON_JAN;
            year_q      <= RST_YEAR;
            leap_q      <= RST_LEAP;
            year_wrap_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            leap_q      <= leap_d;
            year_wrap_q <= year_wrap_d;
            load_err_q  <= load_err_d;
        end
    end

    assign cal.day       = day_q;
    assign cal.month     = month_q;
    assign cal.year      = year_q;
    assign cal.leap      = leap_q;
    assign cal.year_wrap = year_wrap_q;
    assign cal.load_err  = load_err_q;
endmodule

// File: tb/tb_bcd_calendar_counter.sv
// Randomised scoreboard bench: a 4-digit Gregorian counter and a 2-digit
// mod-4 counter run in lockstep against an integer-arithmetic calendar model.
module tb_bcd_calendar_counter;

    typedef struct {
        int d;
        int m;
        int y;
        bit lp;
        bit wrap;
        bit err;
    } mstate_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_next;
    always #5 clk = ~clk;

    bcd_calendar_counter_if #(.YEAR_DIGITS(4)) if4 ();
    bcd_calendar_counter_if #(.YEAR_DIGITS(2)) if2 ();

    bcd_calendar_counter #(
        .YEAR_DIGITS (4),
        .LEAP_MODE   (1),
        .RESET_YEAR  (16'h2000)
    ) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .cal   (if4.slave)
    );

    bcd_calendar_counter #(
        .YEAR_DIGITS (2),
        .LEAP_MODE   (0),
        .RESET_YEAR  (16'h0096)
    ) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .cal   (if2.slave)
    );

    mstate_t s4, s2;
    mstate_t q4[$];
    mstate_t q2[$];
    int checks = 0;
    int errors = 0;

    function automatic bit is_leap(int y, int nd);
        if (nd == 4) return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
        return y % 4 == 0;
    endfunction

    function automatic int dim(int m, bit lp);
        int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && lp) return 29;
        return t[m-1];
    endfunction

    function automatic int bcd_dec(logic [15:0] v, int nd, output bit ok);
        int val = 0;
        int nib;
        ok = 1'b1;
        for (int i = nd - 1; i >= 0; i--) begin
            nib = int'((v >> (4 * i)) & 16'h000f);
            if (nib > 9) ok = 1'b0;
            val = val * 10 + nib;
        end
        return val;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r = '0;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic mstate_t reset_state(int y, int nd);
        mstate_t r;
        r.d = 1; r.m = 1; r.y = y; r.lp = is_leap(y, nd); r.wrap = 0; r.err = 0;
        return r;
    endfunction

    function automatic mstate_t mstep(mstate_t s, int nd, bit tick, bit ld,
                                      logic [7:0] dd, logic [7:0] mm, logic [15:0] yy);
        mstate_t r = s;
        bit okd, okm, oky, good;
        int vd, vm, vy;
        r.wrap = 0;
        r.err  = 0;
        if (ld) begin
            vd = bcd_dec(16'(dd), 2, okd);
            vm = bcd_dec(16'(mm), 2, okm);
            vy = bcd_dec(yy, nd, oky);
            good = okd && okm && oky && vm >= 1 && vm <= 12;
            if (good) good = vd >= 1 && vd <= dim(vm, is_leap(vy, nd));
            if (good) begin
                r.d = vd; r.m = vm; r.y = vy; r.lp = is_leap(vy, nd);
            end else begin
                r.err = 1;
            end
        end else if (tick) begin
            r.d++;
            if (r.d > dim(r.m, r.lp)) begin
                r.d = 1;
                r.m++;
                if (r.m > 12) begin
                    r.m = 1;
                    r.y++;
                    if (r.y == ((nd == 4) ? 10000 : 100)) begin
                        r.y    = 0;
                        r.wrap = 1;
                    end
                    r.lp = is_leap(r.y, nd);
                end
            end
        end
        return r;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic cmp(string tag, mstate_t e, logic [7:0] d, logic [7:0] m,
                       logic [15:0] y, logic lp, logic w, logic er);
        logic [15:0] eb;
        eb = to_bcd(e.d);
        check({tag, ".day"}, 32'(d), 32'(eb[7:0]));
        eb = to_bcd(e.m);
        check({tag, ".month"}, 32'(m), 32'(eb[7:0]));
        check({tag, ".year"}, 32'(y), 32'(to_bcd(e.y)));
        check({tag, ".leap"}, 32'(lp), 32'(e.lp));
        check({tag, ".year_wrap"}, 32'(w), 32'(e.wrap));
        check({tag, ".load_err"}, 32'(er), 32'(e.err));
    endtask

    // Drive one cycle at the falling edge and queue what each counter must show after the next rising edge.
    task automatic cyc(bit tick, bit ld, logic [7:0] dd, logic [7:0] mm, logic [15:0] yy);
        @(negedge clk);
        rst_n = rst_next;
        if4.day_tick = tick; if4.load = ld; if4.load_day = dd; if4.load_month = mm; if4.load_year = yy;
        if2.day_tick = tick; if2.load = ld; if2.load_day = dd; if2.load_month = mm; if2.load_year = yy[7:0];
        if (rst_n) begin
            s4 = mstep(s4, 4, tick, ld, dd, mm, yy);
            s2 = mstep(s2, 2, tick, ld, dd, mm, {8'h00, yy[7:0]});
        end else begin
            s4 = reset_state(2000, 4);
            s2 = reset_state(96, 2);
        end
        q4.push_back(s4);
        q2.push_back(s2);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, 8'h00, 16'h0000);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 8'h00, 16'h0000);
    endtask

    task automatic load_date(logic [7:0] dd, logic [7:0] mm, logic [15:0] yy);
        cyc(1'b0, 1'b1, dd, mm, yy);
    endtask

    // Assert reset away from any edge and confirm the outputs clear without waiting for a clock.
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        rst_next = 1'b0;
        #1;
        s4 = reset_state(2000, 4);
        s2 = reset_state(96, 2);
        cmp("async4", s4, if4.day, if4.month, if4.year, if4.leap, if4.year_wrap, if4.load_err);
        cmp("async2", s2, if2.day, if2.month, 16'(if2.year), if2.leap, if2.year_wrap, if2.load_err);
    endtask

    initial begin : monitor
        mstate_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q4.size() != 0) begin
                e = q4.pop_front();
                cmp("dut4", e, if4.day, if4.month, if4.year, if4.leap, if4.year_wrap, if4.load_err);
            end
            if (q2.size() != 0) begin
                e = q2.pop_front();
                cmp("dut2", e, if2.day, if2.month, 16'(if2.year), if2.leap, if2.year_wrap, if2.load_err);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [15:0] t;
        logic [7:0]  dd, mm;
        logic [15:0] yy;
        int          pick;
        rst_n    = 1'b0;
        rst_next = 1'b0;
        if4.day_tick = 1'b0; if4.load = 1'b0; if4.load_day = '0; if4.load_month = '0; if4.load_year = '0;
        if2.day_tick = 1'b0; if2.load = 1'b0; if2.load_day = '0; if2.load_month = '0; if2.load_year = '0;
        s4 = reset_state(2000, 4);
        s2 = reset_state(96, 2);

        cyc(1'b1, 1'b0, 8'h00, 8'h00, 16'h0000);
        idle(1);
        rst_next = 1'b1;

        // Leap February from reset, across 28 -> 29 -> 01 Mar.
        ticks(60);
        idle(1);

        load_date(8'h28, 8'h02, 16'h1900);
        ticks(1);
        idle(1);

        load_date(8'h31, 8'h12, 16'h9999);
        ticks(1);
        idle(2);

        load_date(8'h31, 8'h04, 16'h2023);
        load_date(8'h29, 8'h02, 16'h2023);
        load_date(8'h1A, 8'h01, 16'h2023);
        load_date(8'h10, 8'h05, 16'h20A3);
        load_date(8'h10, 8'h13, 16'h2023);
        load_date(8'h00, 8'h05, 16'h2023);
        idle(1);

        cyc(1'b1, 1'b1, 8'h15, 8'h06, 16'h2024);
        idle(1);

        load_date(8'h01, 8'h01, 16'h2024);
        ticks(366);
        idle(1);

        load_date(8'h01, 8'h01, 16'h2024);
        ticks(100);
        async_reset();
        ticks(2);
        rst_next = 1'b1;
        ticks(5);

        load_date(8'h29, 8'h02, 16'h2000);
        load_date(8'h29, 8'h02, 16'h2100);
        load_date(8'h29, 8'h02, 16'h2400);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0) begin
                t  = to_bcd($urandom_range(0, 32));
                dd = ($urandom_range(0, 15) == 0) ? 8'($urandom) : t[7:0];
                t  = to_bcd($urandom_range(0, 13));
                mm = ($urandom_range(0, 15) == 0) ? 8'($urandom) : t[7:0];
                case ($urandom_range(0, 7))
                    0: yy = 16'h1900;
                    1: yy = 16'h2000;
                    2: yy = 16'h2100;
                    3: yy = 16'($urandom);
                    4: yy = 16'h9999;
                    default: yy = to_bcd($urandom_range(0, 9999));
                endcase
                if ($urandom_range(0, 3) == 0) begin
                    dd = 8'h29; mm = 8'h02;
                end
                cyc(1'($urandom_range(0, 1)), 1'b1, dd, mm, yy);
            end else begin
                cyc(1'($urandom_range(0, 3) != 0), 1'b0, 8'h00, 8'h00, 16'h0000);
            end
        end

        idle(2);
        @(posedge clk);
        #3;
        check("q4_drained", 32'(q4.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
